// File: rtl/motor_pkg.sv
// Shared types for the motor PWM controller: command modes, channel FSM states and duty type.
package motor_pkg;

  typedef enum logic [1:0] {
    MODE_COAST = 2'b00,
    MODE_FWD   = 2'b01,
    MODE_REV   = 2'b10,
    MODE_BRAKE = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_COAST = 3'd0,
    ST_DEAD  = 3'd1,
    ST_RUN_F = 3'd2,
    ST_RUN_R = 3'd3,
    ST_BRAKE = 3'd4
  } chan_state_t;

  localparam int DUTY_W = 8;
  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/motor_channel.sv
// One H-bridge channel: target latch, direction FSM with dead-time, duty ramp and registered pins.
module motor_channel
  import motor_pkg::*;
#(
  parameter int PWM_W     = 8,
  parameter int DEADTIME  = 16,
  parameter int RAMP_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt,
  input  logic             wrap,
  input  logic             ld,
  input  mode_t            ld_mode,
  input  logic [PWM_W-1:0] ld_duty,
  input  logic             wd_coast,
  output logic             m_fwd,
  output logic             m_bwd,
  output chan_state_t      dbg_state
);

  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  // DEAD holds for DEADTIME cycles: counter runs DEADTIME-1 down to 0.
  localparam logic [DW-1:0]  DEAD_LOAD = DW'(DEADTIME - 1);
  localparam logic [PWM_W:0] STEP_X    = (PWM_W+1)'(RAMP_STEP);

  mode_t            tgt_mode;
  logic [PWM_W-1:0] tgt_duty;
  logic [PWM_W-1:0] cur_duty;
  logic [PWM_W-1:0] ramp_duty;
  logic [PWM_W:0]   cur_x;
  logic [PWM_W:0]   tgt_x;
  logic [DW-1:0]    dcnt;
  chan_state_t      state;
  logic             pwm_on;

  assign dbg_state = state;
  assign pwm_on    = cnt < cur_duty;

  // A command accepted on the watchdog expiry cycle never sees wd_coast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_mode <= MODE_COAST;
      tgt_duty <= '0;
    end else if (ld) begin
      tgt_mode <= ld_mode;
      tgt_duty <= ld_duty;
    end else if (wd_coast) begin
      tgt_mode <= MODE_COAST;
    end
  end

  // One extra bit keeps the step arithmetic free of wrap-around.
  always_comb begin
    cur_x     = {1'b0, cur_duty};
    tgt_x     = {1'b0, tgt_duty};
    ramp_duty = cur_duty;
    if (tgt_x > cur_x) begin
      if (tgt_x - cur_x > STEP_X) ramp_duty = PWM_W'(cur_x + STEP_X);
      else                        ramp_duty = tgt_duty;
    end else if (cur_x > tgt_x) begin
      if (cur_x - tgt_x > STEP_X) ramp_duty = PWM_W'(cur_x - STEP_X);
      else                        ramp_duty = tgt_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_COAST;
      dcnt     <= '0;
      cur_duty <= '0;
      m_fwd    <= 1'b0;
      m_bwd    <= 1'b0;
    end else begin
      m_fwd <= ((state == ST_RUN_F) && pwm_on) || (state == ST_BRAKE);
      m_bwd <= ((state == ST_RUN_R) && pwm_on) || (state == ST_BRAKE);
      case (state)
        ST_COAST: begin
          if (tgt_mode != MODE_COAST) begin
            state <= ST_DEAD;
            dcnt  <= DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (dcnt == '0) begin
            cur_duty <= '0;
            case (tgt_mode)
              MODE_FWD:   state <= ST_RUN_F;
              MODE_REV:   state <= ST_RUN_R;
              MODE_BRAKE: state <= ST_BRAKE;
              default:    state <= ST_COAST;
            endcase
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        ST_RUN_F: begin
          case (tgt_mode)
            MODE_FWD: if (wrap) cur_duty <= ramp_duty;
            MODE_COAST: begin
              state    <= ST_COAST;
              cur_duty <= '0;
            end
            default: begin
              state <= ST_DEAD;
              dcnt  <= DEAD_LOAD;
            end
          endcase
        end
        ST_RUN_R: begin
          case (tgt_mode)
            MODE_REV: if (wrap) cur_duty <= ramp_duty;
            MODE_COAST: begin
              state    <= ST_COAST;
              cur_duty <= '0;
            end
            default: begin
              state <= ST_DEAD;
              dcnt  <= DEAD_LOAD;
            end
          endcase
        end
        ST_BRAKE: begin
          case (tgt_mode)
            MODE_FWD, MODE_REV: begin
              state <= ST_DEAD;
              dcnt  <= DEAD_LOAD;
            end
            MODE_COAST: state <= ST_COAST;
            default: ;
          endcase
        end
        default: state <= ST_COAST;
      endcase
    end
  end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// N-channel H-bridge controller: shared PWM counter, command decode, command watchdog,
// and one motor_channel per bridge.
module motor_pwm_ctrl
  import motor_pkg::*;
#(
  parameter int NUM_MOTORS = 2,
  parameter int PWM_W      = 8,
  parameter int DEADTIME   = 16,
  parameter int RAMP_STEP  = 4,
  parameter int WDOG_CYC   = 2**20,
  localparam int MW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [MW-1:0]                 cmd_motor,
  input  logic [1:0]                    cmd_mode,
  input  logic [PWM_W-1:0]              cmd_duty,
  output logic [NUM_MOTORS-1:0]         m_fwd,
  output logic [NUM_MOTORS-1:0]         m_bwd,
  output logic                          wdog_trip,
  output chan_state_t [NUM_MOTORS-1:0]  dbg_state
);

  localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'((2**PWM_W) - 2);
  localparam int               WW      = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0]    WD_LAST = WW'(WDOG_CYC - 1);
  localparam logic [WW-1:0]    WD_HOLD = WW'(WDOG_CYC);
  localparam logic [MW:0]      NM      = (MW+1)'(NUM_MOTORS);

  logic [PWM_W-1:0]      cnt;
  logic                  wrap;
  logic                  accept;
  logic                  cmd_ok;
  logic                  wd_expire;
  logic [WW-1:0]         wd_cnt;
  logic [NUM_MOTORS-1:0] ld;

  // Handshake: a command transfers on any rising edge with cmd_valid && cmd_ready; the
  // command fields must be stable while cmd_valid is high. Commands for a non-existent
  // channel still transfer (and feed the watchdog) but are discarded, and cmd_ready drops
  // for the following cycle.
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_ok    = {1'b0, cmd_motor} < NM;
  assign wrap      = cnt == CNT_MAX;
  assign wd_expire = !accept && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (wrap) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // After expiry the counter parks at WD_HOLD so the coast request fires once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      wd_cnt    <= '0;
      wdog_trip <= 1'b0;
    end else begin
      cmd_ready <= !(accept && !cmd_ok);
      if (accept) begin
        wd_cnt    <= '0;
        wdog_trip <= 1'b0;
      end else if (wd_expire) begin
        wd_cnt    <= WD_HOLD;
        wdog_trip <= 1'b1;
      end else if (wd_cnt != WD_HOLD) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ld = '0;
    for (int i = 0; i < NUM_MOTORS; i++) begin
      ld[i] = accept && cmd_ok && (cmd_motor == MW'(i));
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
    motor_channel #(
      .PWM_W     (PWM_W),
      .DEADTIME  (DEADTIME),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt       (cnt),
      .wrap      (wrap),
      .ld        (ld[g]),
      .ld_mode   (mode_t'(cmd_mode)),
      .ld_duty   (cmd_duty),
      .wd_coast  (wd_expire),
      .m_fwd     (m_fwd[g]),
      .m_bwd     (m_bwd[g]),
      .dbg_state (dbg_state[g])
    );
  end

endmodule
